lopd_norm_pipe: RTL and testbench
=================================

LOPD_NORM_PIPE -- requirements
Module: lopd_norm_pipe

Interface
REQ-001 The block SHALL have parameter SIZE_DATA, default 24, meaning the operand width (legal range 8..64).
REQ-002 The block SHALL have parameter SIZE_LOPD, default 5, meaning the position field width; it SHALL satisfy 2**SIZE_LOPD >= SIZE_DATA.
REQ-003 The block SHALL have parameter SIZE_TAG, default 4, meaning the sideband tag width carried alongside each operand.
REQ-004 Port i_clk: input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 Port i_rst_n: input, 1 bit, synchronous active-low reset.
REQ-006 Port i_valid: input, 1 bit, upstream operand valid.
REQ-007 Port o_ready: output, 1 bit, block accepts an operand this cycle.
REQ-008 Port i_data: input, SIZE_DATA bits, operand to scan.
REQ-009 Port i_tag: input, SIZE_TAG bits, sideband passed through unchanged.
REQ-010 Port o_valid: output, 1 bit, result valid.
REQ-011 Port i_ready: input, 1 bit, downstream accepts the result.
REQ-012 Port o_one_position: output, SIZE_LOPD bits, leading-zero count measured from the MSB.
REQ-013 Port o_zero_flag: output, 1 bit, operand was all zeros.
REQ-014 Port o_norm_data: output, SIZE_DATA bits, operand left-shifted by o_one_position.
REQ-015 Port o_tag: output, SIZE_TAG bits, tag of the result.

Function
REQ-016 Transfer SHALL occur on a cycle with i_valid&o_ready (input) or o_valid&i_ready (output).
REQ-017 Pipeline SHALL be two register stages: S1 registers the position, zero flag, data and tag; S2 registers the shifted data, position, zero flag and tag.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to o_valid with no stall, and throughput SHALL be one operand per cycle.
REQ-019 Each stage SHALL load when it is empty or its content moves on the same cycle; o_ready = ~S1_valid | ~S2_valid | i_ready, and the combinational path from i_ready to o_ready is permitted.
REQ-020 While o_valid=1 and i_ready=0, all result outputs SHALL hold stable.
REQ-021 Results SHALL leave in acceptance order, with no loss or duplication under any i_valid/i_ready pattern.
REQ-022 o_one_position SHALL equal the number of zero bits above the highest set bit; MSB set gives 0 and only LSB set gives SIZE_DATA-1.
REQ-023 For a zero operand: o_zero_flag=1, o_one_position all ones, o_norm_data=0.
REQ-024 o_norm_data SHALL equal i_data << o_one_position truncated to SIZE_DATA bits, so its MSB is 1 when o_zero_flag=0.
REQ-025 o_tag SHALL equal the i_tag accepted with the same operand.
REQ-026 Input transfer and output transfer on the same cycle SHALL both complete; pipeline occupancy stays unchanged.
REQ-027 i_data and i_tag SHALL be ignored when i_valid=0.

Reset
REQ-028 With i_rst_n=0 at a clock edge, both stage valids SHALL clear, so o_valid=0 from the next cycle.
REQ-029 Reset values SHALL be: o_one_position=0, o_zero_flag=0, o_norm_data=0, o_tag=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operands with no result emitted for them.
REQ-031 o_ready SHALL be 1 in the first cycle after reset deassertion.

Configuration
REQ-032 Macro LOPD_NORM_SHIFT_EN defined: the normalising shifter in S2 SHALL be built and o_norm_data behaves per REQ-024.
REQ-033 Macro LOPD_NORM_SHIFT_EN undefined: no shifter SHALL be built and o_norm_data SHALL be constant 0; latency, handshake and all other outputs are unchanged.

Verification (SIZE_DATA=24, SIZE_LOPD=5, macro defined unless noted)
REQ-034 Input i_data=24'h800000, tag=3, i_ready=1 -> 2 cycles later o_valid=1, position=0, zero=0, norm=24'h800000, tag=3.
REQ-035 Input i_data=24'h000001 -> position=23, norm=24'h800000; input 24'h00F000 -> position=8, norm=24'hF00000.
REQ-036 Input i_data=0 -> o_zero_flag=1, position=5'b11111, norm=0.
REQ-037 Three back-to-back operands, i_ready=0 for 4 cycles -> o_ready falls after the second accept, the held result stays stable, and the order is preserved after release.
REQ-038 Reset pulsed one cycle after two accepts -> o_valid stays 0 and no stale result appears.
REQ-039 Macro undefined, input 24'h000001 -> position=23, o_norm_data=0, latency 2.

Source files
------------

// File: rtl/lopd_norm_pipe.sv
// -----------------------------------------------------------------------------
// lopd_norm_pipe
//
// Two-stage pipelined leading-one position detector with an optional
// normalising left shifter.
//   S1 : leading-zero count, zero flag, operand and tag are registered.
//   S2 : the operand is shifted left by the count (when the shifter is built)
//        and registered together with the count, zero flag and tag.
// Both stages use valid/ready handshakes. A stage loads when it is empty or
// when its content leaves on the same cycle. The result is valid two cycles
// after acceptance, and the pipe sustains one operand per cycle.
//
// Configuration macro:
//   LOPD_NORM_SHIFT_EN  defined   -> S2 shifter built, o_norm_data = data << pos
//                       undefined -> no shifter, o_norm_data tied to 0
//
// Ports:
//   i_clk           rising-edge clock
//   i_rst_n         synchronous active-low reset
//   i_valid/o_ready input handshake; i_data operand, i_tag sideband
//   o_valid/i_ready output handshake
//   o_one_position  zeros above the highest set bit (all ones for zero input)
//   o_zero_flag     operand was all zeros
//   o_norm_data     normalised operand (0 when the shifter is not built)
//   o_tag           tag accepted with the operand
// -----------------------------------------------------------------------------
module lopd_norm_pipe #(
  parameter int SIZE_DATA = 24,
  parameter int SIZE_LOPD = 5,
  parameter int SIZE_TAG  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic [SIZE_TAG-1:0]  i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_LOPD-1:0] o_one_position,
  output logic                 o_zero_flag,
  output logic [SIZE_DATA-1:0] o_norm_data,
  output logic [SIZE_TAG-1:0]  o_tag
);

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic s1_valid, s2_valid;
  logic s1_load, s2_load;

  // S2 may take new content when empty or when its result leaves this cycle;
  // S1 may take new content when empty or when it can move into S2.
  assign s2_load = ~s2_valid | i_ready;
  assign s1_load = ~s1_valid | s2_load;
  assign o_ready = s1_load;
  assign o_valid = s2_valid;

  // ---------------------------------------------------------------------------
  // Leading-one detection (combinational, in front of S1)
  // ---------------------------------------------------------------------------
  logic [SIZE_LOPD-1:0] lead_pos;
  logic                 lead_zero;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    lead_pos  = '1;
    lead_zero = 1'b1;
    // Scanning upward lets the highest set bit win, because it is assigned last.
    for (int i = 0; i < SIZE_DATA; i++) begin
      if (i_data[i]) begin
        lead_pos  = SIZE_LOPD'(SIZE_DATA - 1 - i);
        lead_zero = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------
  logic [SIZE_LOPD-1:0] s1_pos;
  logic                 s1_zero;
  logic [SIZE_TAG-1:0]  s1_tag;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of the order of the statements.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_pos   <= '0;
      s1_zero  <= 1'b0;
      s1_tag   <= '0;
    end else if (s1_load) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_pos  <= lead_pos;
        s1_zero <= lead_zero;
        s1_tag  <= i_tag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2
  // ---------------------------------------------------------------------------
  logic [SIZE_LOPD-1:0] s2_pos;
  logic                 s2_zero;
  logic [SIZE_TAG-1:0]  s2_tag;

  // NOTE: the datapath registers are reset as well, because the result outputs
  // have defined values while the pipe is empty after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_pos   <= '0;
      s2_zero  <= 1'b0;
      s2_tag   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_pos  <= s1_pos;
        s2_zero <= s1_zero;
        s2_tag  <= s1_tag;
      end
    end
  end

  assign o_one_position = s2_pos;
  assign o_zero_flag    = s2_zero;
  assign o_tag          = s2_tag;

  // ---------------------------------------------------------------------------
  // Normalising shifter
  // ---------------------------------------------------------------------------
`ifdef LOPD_NORM_SHIFT_EN
  logic [SIZE_DATA-1:0] s1_data;
  logic [SIZE_DATA-1:0] s2_norm;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_data <= '0;
    end else if (s1_load && i_valid) begin
      s1_data <= i_data;
    end
  end

  // A zero operand has an all-ones count, but shifting zero still yields zero,
  // so no special case is needed.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_norm <= '0;
    end else if (s2_load && s1_valid) begin
      s2_norm <= s1_data << s1_pos;
    end
  end

  assign o_norm_data = s2_norm;
`else
  // Without the shifter the operand is not needed past the detector.
  assign o_norm_data = '0;
`endif

endmodule

// File: tb/tb_lopd_norm_pipe.sv
// -----------------------------------------------------------------------------
// tb_lopd_norm_pipe
//
// Self-checking bench for lopd_norm_pipe (SIZE_DATA=24, SIZE_LOPD=5,
// SIZE_TAG=4). The reference model is a queue of accepted operands with their
// acceptance cycle. Expected results come from plain arithmetic on the
// operand. Expected o_valid and o_ready come from the queue occupancy and the
// age of the oldest entry. LOPD_NORM_SHIFT_EN selects the expected o_norm_data.
// -----------------------------------------------------------------------------
module tb_lopd_norm_pipe;

  localparam int SD = 24;
  localparam int SL = 5;
  localparam int ST = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [SD-1:0] i_data;
  logic [ST-1:0] i_tag;
  logic          o_valid;
  logic          i_ready;
  logic [SL-1:0] o_one_position;
  logic          o_zero_flag;
  logic [SD-1:0] o_norm_data;
  logic [ST-1:0] o_tag;

  lopd_norm_pipe #(.SIZE_DATA(SD), .SIZE_LOPD(SL), .SIZE_TAG(ST)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data         (i_data),
    .i_tag          (i_tag),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_one_position (o_one_position),
    .o_zero_flag    (o_zero_flag),
    .o_norm_data    (o_norm_data),
    .o_tag          (o_tag)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [SD-1:0] data;
    logic [ST-1:0] tag;
    int            acc;
  } item_t;

  item_t q[$];
  int    cyc     = 0;
  int    n_cmp   = 0;
  int    n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leading-zero count from the MSB; 31 stands in for the all-ones zero code.
  function automatic int ref_pos(input logic [SD-1:0] d);
    int n;
    if (d == 0) return (1 << SL) - 1;
    n = 0;
    while (d[SD-1-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic [SD-1:0] ref_norm(input logic [SD-1:0] d);
`ifdef LOPD_NORM_SHIFT_EN
    logic [63:0] wide;
    wide = 64'(d) << ref_pos(d);
    return wide[SD-1:0];
`else
    return '0;
`endif
  endfunction

  // One clock cycle: apply inputs, check at the falling edge, then advance the
  // model through the rising edge. Entered and left 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [SD-1:0] d, input logic [ST-1:0] t,
                      input logic r);
    logic exp_ready, exp_valid, do_acc, do_emit;
    i_valid = v;
    i_data  = d;
    i_tag   = t;
    i_ready = r;
    @(negedge i_clk);
    exp_ready = (q.size() < 2) || r;
    exp_valid = (q.size() > 0) && (cyc - q[0].acc >= 1);
    check("o_ready", 64'(o_ready), 64'(exp_ready));
    check("o_valid", 64'(o_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("position", 64'(o_one_position), 64'(ref_pos(q[0].data)));
      check("zero",     64'(o_zero_flag),    64'(q[0].data == 0));
      check("norm",     64'(o_norm_data),    64'(ref_norm(q[0].data)));
      check("tag",      64'(o_tag),          64'(q[0].tag));
    end
    do_acc  = v && exp_ready;
    do_emit = exp_valid && r;
    @(posedge i_clk);
    cyc++;
    if (do_emit) void'(q.pop_front());
    if (do_acc) q.push_back('{data: d, tag: t, acc: cyc});
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b1;          // ignored while reset is asserted
    i_ready = 1'b0;
    i_data  = 24'h123456;
    i_tag   = 4'hA;
    @(posedge i_clk);
    @(posedge i_clk);
    cyc += 2;
    #1;
    q.delete();
    check("rst_valid", 64'(o_valid),        64'd0);
    check("rst_pos",   64'(o_one_position), 64'd0);
    check("rst_zero",  64'(o_zero_flag),    64'd0);
    check("rst_norm",  64'(o_norm_data),    64'd0);
    check("rst_tag",   64'(o_tag),          64'd0);
    i_rst_n = 1'b1;
  endtask

  function automatic logic [SD-1:0] rand_data();
    logic [31:0] r;
    r = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 15) == 0) r = '0;
    return r[SD-1:0];
  endfunction

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;
    i_tag   = '0;
    @(posedge i_clk);
    #1;

    // Reset values, then ready in the first cycle after release.
    do_reset();
    step(1'b0, 24'hABCDEF, 4'h5, 1'b1);

    // Directed operands: MSB only, LSB only, mid-range, zero.
    step(1'b1, 24'h800000, 4'd3, 1'b1);
    step(1'b1, 24'h000001, 4'd7, 1'b1);
    step(1'b1, 24'h00F000, 4'd9, 1'b1);
    step(1'b1, 24'h000000, 4'd1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 24'hFFFFFF, 4'hF, 1'b1);

    // Three back-to-back operands against a 4-cycle stall, then release.
    step(1'b1, 24'h040000, 4'd2, 1'b0);
    step(1'b1, 24'h000300, 4'd4, 1'b0);
    step(1'b1, 24'h7FFFFF, 4'd6, 1'b0);
    step(1'b1, 24'h7FFFFF, 4'd6, 1'b0);
    step(1'b1, 24'h7FFFFF, 4'd6, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 24'h0, 4'h0, 1'b1);

    // Reset one cycle after two accepts: nothing in flight may come out.
    step(1'b1, 24'h001000, 4'd8, 1'b0);
    step(1'b1, 24'h000010, 4'd9, 1'b0);
    step(1'b0, 24'h000000, 4'd0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 24'h0, 4'h0, 1'b1);

    // Random valid/ready/data traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rand_data(), 4'($urandom),
           1'($urandom_range(0, 2) != 0));

    // Bounded drain.
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, rand_data(), 4'h0, 1'b1);
    check("drain_empty", 64'(q.size()), 64'd0);
    step(1'b0, 24'h0, 4'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
